prbs31_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for the PRBS31 (x^31+x^28+1) datapath.

---
 rtl/prbs31_bist_ctrl.sv | 166 ++++++++++++++++
 tb/tb_prbs31_bist_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_bist_ctrl.sv
// prbs31_bist_ctrl
// Built-in self-test sequencer for a PRBS31 (x^31 + x^28 + 1) serial loopback.
// A generator LFSR drives tx_bit. A checker LFSR first captures 31 looped-back
// bits. It then runs free and predicts every following bit, and the controller
// counts the predicted bits that disagree with rx_bit.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous reset, active HIGH (rst_n=1 resets)
//   start      in   1      launches a run from IDLE or DONE
//   abort      in   1      returns to IDLE on the next edge from any state
//   err_inject in   1      inverts tx_bit while high, only in CHECK
//   rx_bit     in   1      looped-back serial bit, any fixed latency
//   tx_bit     out  1      generator output (gen[30])
//   busy       out  1      run in progress (LOCK or CHECK)
//   done       out  1      run finished (DONE)
//   pass       out  1      locked and no errors (valid in DONE)
//   no_lock    out  1      checker captured all-zero state (valid in DONE)
//   err_cnt    out  ERR_W  saturating mismatch count
module prbs31_bist_ctrl #(
  parameter int          NBITS = 1024,
  parameter logic [30:0] SEED  = 31'd1,
  parameter int          ERR_W = 16,
  parameter int          CNT_W = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             err_inject,
  input  logic             rx_bit,
  output logic             tx_bit,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             no_lock,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // An all-zero seed would lock the generator, so it is replaced by 1.
  localparam logic [30:0]      SEED_EFF = (SEED == 31'd0) ? 31'd1 : SEED;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  function automatic logic [30:0] lfsr_step(input logic [30:0] r);
    return {r[29:0], r[27] ^ r[30]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t           state_q;
  logic [30:0]      gen_q;
  logic [30:0]      chk_q;
  logic [4:0]       lock_cnt_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             no_lock_q;

  logic [30:0]      gen_d;
  logic [30:0]      chk_cap_d;
  logic [30:0]      chk_run_d;
  logic             predicted;
  logic             mismatch;
  logic [ERR_W-1:0] err_cnt_d;

  always_comb begin
    gen_d     = lfsr_step(gen_q);
    // LOCK: shift in the received bit; CHECK: the checker feeds itself, so a
    // single corrupted rx bit produces exactly one mismatch.
    chk_cap_d = {chk_q[29:0], rx_bit};
    predicted = chk_q[27] ^ chk_q[30];
    chk_run_d = {chk_q[29:0], predicted};
    mismatch  = (rx_bit != predicted);
    err_cnt_d = mismatch ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      gen_q      <= SEED_EFF;
      chk_q      <= '0;
      lock_cnt_q <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      no_lock_q  <= 1'b0;
    end else if (abort) begin
      state_q    <= S_IDLE;
      gen_q      <= SEED_EFF;
      lock_cnt_q <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      no_lock_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // DONE keeps the generator frozen where the run ended.
          if (state_q == S_IDLE) gen_q <= SEED_EFF;
          if (start) begin
            state_q    <= S_LOCK;
            chk_q      <= '0;
            lock_cnt_q <= '0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            no_lock_q  <= 1'b0;
          end
        end
        S_LOCK: begin
          gen_q      <= gen_d;
          chk_q      <= chk_cap_d;
          lock_cnt_q <= lock_cnt_q + 5'd1;
          if (lock_cnt_q == 5'd30) begin
            if (chk_cap_d == 31'd0) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              no_lock_q <= 1'b1;
            end else begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          gen_q     <= gen_d;
          chk_q     <= chk_run_d;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          err_cnt_q <= err_cnt_d;
          if (bit_cnt_q == LAST_BIT) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_bit  = gen_q[30] ^ (err_inject & (state_q == S_CHECK));
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign no_lock = no_lock_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prbs31_bist_ctrl.sv
// Testbench for prbs31_bist_ctrl. It uses three instances:
//   A: default parameters, 0-delay loopback (or rx tied low).
//   B: 5-cycle loopback delay, with a seed whose history is five zeros.
//   C: ERR_W=4 and an inverted loopback.
module tb_prbs31_bist_ctrl;
  localparam int          NB_A   = 1024;
  localparam int          NB_B   = 256;
  localparam int          NB_C   = 64;
  localparam logic [30:0] SEED_A = 31'd1;
  localparam logic [30:0] SEED_B = 31'h20;
  localparam int          MLEN   = 1400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference PRBS sequences: s[k] = seed[30-k] for k<31, then s[n] = s[n-28]^s[n-31].
  bit seq_a [0:MLEN-1];
  bit seq_b [0:MLEN-1];
  bit rx_m  [0:MLEN-1];
  bit tx_m  [0:MLEN-1];

  // Instance A
  logic start_a = 0, abort_a = 0, inj_a = 0, rx_zero_a = 0;
  logic rx_a, tx_a, busy_a, done_a, pass_a, nolock_a;
  logic [15:0] err_a;
  assign rx_a = rx_zero_a ? 1'b0 : tx_a;

  prbs31_bist_ctrl #(.NBITS(NB_A), .SEED(SEED_A), .ERR_W(16)) dut_a (
    .clk(clk), .rst_n(rst), .start(start_a), .abort(abort_a), .err_inject(inj_a),
    .rx_bit(rx_a), .tx_bit(tx_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .no_lock(nolock_a), .err_cnt(err_a));

  // Instance B: fixed 5-cycle loopback delay
  logic start_b = 0, abort_b = 0, inj_b = 0;
  logic rx_b, tx_b, busy_b, done_b, pass_b, nolock_b;
  logic [15:0] err_b;
  logic [4:0]  dly_b = '0;
  always @(posedge clk) dly_b <= {dly_b[3:0], tx_b};
  assign rx_b = dly_b[4];

  prbs31_bist_ctrl #(.NBITS(NB_B), .SEED(SEED_B), .ERR_W(16)) dut_b (
    .clk(clk), .rst_n(rst), .start(start_b), .abort(abort_b), .err_inject(inj_b),
    .rx_bit(rx_b), .tx_bit(tx_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .no_lock(nolock_b), .err_cnt(err_b));

  // Instance C: inverted loopback, 4-bit error counter
  logic start_c = 0, abort_c = 0, inj_c = 0;
  logic rx_c, tx_c, busy_c, done_c, pass_c, nolock_c;
  logic [3:0] err_c;
  assign rx_c = ~tx_c;

  prbs31_bist_ctrl #(.NBITS(NB_C), .SEED(SEED_A), .ERR_W(4)) dut_c (
    .clk(clk), .rst_n(rst), .start(start_c), .abort(abort_c), .err_inject(inj_c),
    .rx_bit(rx_c), .tx_bit(tx_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .no_lock(nolock_c), .err_cnt(err_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_seqs();
    logic [30:0] sa;
    logic [30:0] sb;
    sa = SEED_A;
    sb = SEED_B;
    for (int k = 0; k < 31; k++) begin
      seq_a[k] = sa[30-k];
      seq_b[k] = sb[30-k];
    end
    for (int n = 31; n < MLEN; n++) begin
      seq_a[n] = seq_a[n-28] ^ seq_a[n-31];
      seq_b[n] = seq_b[n-28] ^ seq_b[n-31];
    end
  endtask

  // Checker reference: the first 31 received bits form the window; each later
  // bit is predicted from the recurrence on previously predicted bits.
  function automatic int model_errs(input int nbits, input int errmax);
    bit w [0:MLEN-1];
    int e;
    e = 0;
    for (int i = 0; i < 31; i++) w[i] = rx_m[i];
    for (int n = 31; n < 31 + nbits; n++) begin
      w[n] = w[n-28] ^ w[n-31];
      if (w[n] != rx_m[n]) e++;
    end
    return (e > errmax) ? errmax : e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) tick();
    n_cmp++; if (tx_a !== 1'b0)     begin n_bad++; $display("FAIL reset_tx: got %0b want 0", tx_a); end
    n_cmp++; if (busy_a !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %0b want 0", done_a); end
    n_cmp++; if (pass_a !== 1'b0)   begin n_bad++; $display("FAIL reset_pass: got %0b want 0", pass_a); end
    n_cmp++; if (nolock_a !== 1'b0) begin n_bad++; $display("FAIL reset_nolock: got %0b want 0", nolock_a); end
    n_cmp++; if (err_a !== 16'd0)   begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_a); end
    rst = 1'b0;
    tick();
    n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0)
      begin n_bad++; $display("FAIL idle_after_reset: busy %0b done %0b want 0 0", busy_a, done_a); end
  endtask

  task automatic test_run_pass();
    int k, tx_bad, exp;
    rx_zero_a = 1'b0;
    repeat ($urandom_range(2, 9)) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    k = 0; tx_bad = 0;
    while (done_a !== 1'b1 && k < 3000) begin
      if (k < 1000 && tx_a !== seq_a[k]) tx_bad++;
      // Random err_inject pulses during LOCK must have no effect.
      inj_a = (k <= 30) && ($urandom_range(0, 3) == 0);
      tick();
      inj_a = 1'b0;
      k++;
    end
    for (int i = 0; i < MLEN; i++) rx_m[i] = seq_a[i];
    exp = model_errs(NB_A, 65535);
    n_cmp++; if (tx_bad != 0)       begin n_bad++; $display("FAIL tx_stream: %0d wrong bits, want 0", tx_bad); end
    n_cmp++; if (k != 31 + NB_A)    begin n_bad++; $display("FAIL run_len: got %0d want %0d", k, 31 + NB_A); end
    n_cmp++; if (pass_a !== 1'b1)   begin n_bad++; $display("FAIL run_pass: got %0b want 1", pass_a); end
    n_cmp++; if (err_a !== 16'(exp)) begin n_bad++; $display("FAIL run_err: got %0d want %0d", err_a, exp); end
    n_cmp++; if (nolock_a !== 1'b0) begin n_bad++; $display("FAIL run_nolock: got %0b want 0", nolock_a); end
    n_cmp++; if (busy_a !== 1'b0)   begin n_bad++; $display("FAIL run_busy: got %0b want 0", busy_a); end
  endtask

  task automatic test_back_to_back();
    int k, tx_bad;
    repeat ($urandom_range(3, 12)) tick();
    n_cmp++; if (done_a !== 1'b1 || pass_a !== 1'b1)
      begin n_bad++; $display("FAIL done_hold: done %0b pass %0b want 1 1", done_a, pass_a); end
    n_cmp++; if (tx_a !== seq_a[31 + NB_A])
      begin n_bad++; $display("FAIL done_frozen_tx: got %0b want %0b", tx_a, seq_a[31 + NB_A]); end
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_cmp++; if (busy_a !== 1'b1 || done_a !== 1'b0 || pass_a !== 1'b0)
      begin n_bad++; $display("FAIL restart_flags: busy %0b done %0b pass %0b want 1 0 0", busy_a, done_a, pass_a); end
    k = 0; tx_bad = 0;
    while (done_a !== 1'b1 && k < 3000) begin
      if (k < 100 && tx_a !== seq_a[31 + NB_A + k]) tx_bad++;
      tick();
      k++;
    end
    n_cmp++; if (tx_bad != 0)     begin n_bad++; $display("FAIL b2b_tx: %0d wrong bits, want 0", tx_bad); end
    n_cmp++; if (k != 31 + NB_A)  begin n_bad++; $display("FAIL b2b_len: got %0d want %0d", k, 31 + NB_A); end
    n_cmp++; if (pass_a !== 1'b1) begin n_bad++; $display("FAIL b2b_pass: got %0b want 1", pass_a); end
  endtask

  task automatic test_abort();
    int k, p0, p1, p2, exp;
    p0 = 31 + $urandom_range(0, 29);
    p1 = 61 + $urandom_range(0, 29);
    p2 = 91 + $urandom_range(0, 30);
    start_a = 1'b1; tick(); start_a = 1'b0;
    k = 0;
    while (k < 131) begin
      inj_a = (k == p0) || (k == p1) || (k == p2);
      tick();
      inj_a = 1'b0;
      k++;
    end
    // 0-delay loopback: received stream is the PRBS with the injected bits flipped.
    for (int i = 0; i < MLEN; i++)
      rx_m[i] = seq_a[i] ^ ((i == p0) || (i == p1) || (i == p2));
    exp = model_errs(100, 65535);
    n_cmp++; if (err_a !== 16'(exp) || busy_a !== 1'b1)
      begin n_bad++; $display("FAIL pre_abort: err %0d busy %0b want %0d 1", err_a, busy_a, exp); end
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    n_cmp++; if (busy_a !== 1'b0)  begin n_bad++; $display("FAIL abort_busy: got %0b want 0", busy_a); end
    n_cmp++; if (err_a !== 16'd0)  begin n_bad++; $display("FAIL abort_err: got %0d want 0", err_a); end
    n_cmp++; if (done_a !== 1'b0 || pass_a !== 1'b0)
      begin n_bad++; $display("FAIL abort_flags: done %0b pass %0b want 0 0", done_a, pass_a); end
    n_cmp++; if (tx_a !== seq_a[0]) begin n_bad++; $display("FAIL abort_seed: got %0b want %0b", tx_a, seq_a[0]); end
  endtask

  task automatic test_no_lock();
    int k;
    rx_zero_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    k = 0;
    while (done_a !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    n_cmp++; if (k != 31)           begin n_bad++; $display("FAIL nolock_len: got %0d want 31", k); end
    n_cmp++; if (nolock_a !== 1'b1) begin n_bad++; $display("FAIL nolock_flag: got %0b want 1", nolock_a); end
    n_cmp++; if (pass_a !== 1'b0)   begin n_bad++; $display("FAIL nolock_pass: got %0b want 0", pass_a); end
    n_cmp++; if (err_a !== 16'd0)   begin n_bad++; $display("FAIL nolock_err: got %0d want 0", err_a); end
    rx_zero_a = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    // Reset in DONE with start raised: reset wins and clears the flags.
    rst = 1'b1; start_a = 1'b1; tick(); rst = 1'b0; start_a = 1'b0;
    n_cmp++; if (done_a !== 1'b0 || nolock_a !== 1'b0 || busy_a !== 1'b0)
      begin n_bad++; $display("FAIL reset_done_state: done %0b nolock %0b busy %0b want 0 0 0", done_a, nolock_a, busy_a); end
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat ($urandom_range(3, 25)) tick();
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL mid_lock_busy: got %0b want 1", busy_a); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || nolock_a !== 1'b0 || err_a !== 16'd0 || tx_a !== 1'b0)
      begin n_bad++; $display("FAIL mid_lock_reset: busy %0b done %0b pass %0b nolock %0b err %0d tx %0b want all 0",
                              busy_a, done_a, pass_a, nolock_a, err_a, tx_a); end
  endtask

  task automatic test_start_abort();
    start_a = 1'b1; abort_a = 1'b1; tick(); start_a = 1'b0; abort_a = 1'b0;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL start_abort_busy: got %0b want 0", busy_a); end
    repeat (3) tick();
    n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0)
      begin n_bad++; $display("FAIL start_abort_idle: busy %0b done %0b want 0 0", busy_a, done_a); end
  endtask

  task automatic test_err_inject();
    int k, p0, p1, p2, exp;
    logic [30:0] sb;
    sb = SEED_B;
    p0 = 31 + $urandom_range(0, 79);
    p1 = 31 + 80 + $urandom_range(0, 79);
    p2 = 31 + 160 + $urandom_range(0, 80);
    for (int i = 0; i < MLEN; i++)
      tx_m[i] = seq_b[i] ^ ((i == p0) || (i == p1) || (i == p2));
    // Before the run the idle generator sends seed bit 30.
    for (int i = 0; i < MLEN; i++) rx_m[i] = (i < 5) ? sb[30] : tx_m[i-5];
    exp = model_errs(NB_B, 65535);
    repeat (6) tick();
    start_b = 1'b1; tick(); start_b = 1'b0;
    k = 0;
    while (done_b !== 1'b1 && k < 1000) begin
      inj_b = (k == p0) || (k == p1) || (k == p2);
      tick();
      inj_b = 1'b0;
      k++;
    end
    n_cmp++; if (k != 31 + NB_B)      begin n_bad++; $display("FAIL inj_len: got %0d want %0d", k, 31 + NB_B); end
    n_cmp++; if (err_b !== 16'(exp))  begin n_bad++; $display("FAIL inj_err: got %0d want %0d", err_b, exp); end
    n_cmp++; if (pass_b !== (exp == 0)) begin n_bad++; $display("FAIL inj_pass: got %0b want %0b", pass_b, exp == 0); end
    n_cmp++; if (nolock_b !== 1'b0)   begin n_bad++; $display("FAIL inj_nolock: got %0b want 0", nolock_b); end
  endtask

  task automatic test_saturate();
    int k, exp_mid, exp_end;
    for (int i = 0; i < MLEN; i++) rx_m[i] = ~seq_a[i];
    exp_mid = model_errs(10, 15);
    exp_end = model_errs(NB_C, 15);
    start_c = 1'b1; tick(); start_c = 1'b0;
    k = 0;
    while (done_c !== 1'b1 && k < 500) begin
      if (k == 41) begin
        n_cmp++; if (err_c !== 4'(exp_mid))
          begin n_bad++; $display("FAIL sat_mid: got %0d want %0d", err_c, exp_mid); end
      end
      tick();
      k++;
    end
    n_cmp++; if (k != 31 + NB_C)         begin n_bad++; $display("FAIL sat_len: got %0d want %0d", k, 31 + NB_C); end
    n_cmp++; if (err_c !== 4'(exp_end))  begin n_bad++; $display("FAIL sat_err: got %0d want %0d", err_c, exp_end); end
    n_cmp++; if (pass_c !== 1'b0)        begin n_bad++; $display("FAIL sat_pass: got %0b want 0", pass_c); end
  endtask

  initial begin
    fill_seqs();
    test_reset();
    test_run_pass();
    test_back_to_back();
    test_abort();
    test_no_lock();
    test_reset_mid_run();
    test_start_abort();
    test_err_inject();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
